// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types and cycle-count helper for the CC orientation controller
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    LOCKED = 2'd2
  } cc_state_e;

  // Converts a duration into clock cycles: khz * t / div, evaluated in 32 bits.
  function automatic logic [31:0] cc_cycles(input logic [31:0] khz,
                                            input logic [31:0] t,
                                            input logic [31:0] div);
    return (khz * t) / div;
  endfunction

endpackage

// File: rtl/cc_sync_deb.sv
// rtl/cc_sync_deb.sv - two-flop synchroniser and stability counter for both CC comparators
module cc_sync_deb #(
  parameter int unsigned DEB_CYC = 10
) (
  input  logic clock,
  input  logic nrst,
  input  logic phy_in_cc1,
  input  logic phy_in_cc2,
  output logic sc1,
  output logic sc2,
  output logic stable
);

  localparam int unsigned CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYC);

  logic [1:0]    meta_q, sync_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
      prev_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      meta_q <= {phy_in_cc2, phy_in_cc1};
      sync_q <= meta_q;
      prev_q <= sync_q;
      cnt_q  <= cnt_d;
    end
  end

  // A change seen this cycle also masks a saturated count from the old value.
  always_comb begin
    chg   = (sync_q != prev_q);
    cnt_d = cnt_q;
    if (chg) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign sc1    = sync_q[0];
  assign sc2    = sync_q[1];
  assign stable = (cnt_q == DEB_MAX) && !chg;

endmodule

// File: rtl/cc_orient_ctrl.sv
// rtl/cc_orient_ctrl.sv - CC orientation detection FSM, recheck timer and BMC path steering
module cc_orient_ctrl
  import cc_pkg::*;
#(
  parameter int unsigned SYSTEM_KHZ   = 200000,
  parameter int unsigned DEBOUNCE_US  = 20,
  parameter int unsigned SAMPLE_TO_US = 200,
  parameter int unsigned RECHECK_MS   = 10,
  parameter bit          RX_MASK      = 1'b1
) (
  input  logic       clock,
  input  logic       nrst,
  output logic       cc_din,
  input  logic       cc_dout,
  input  logic       cc_check,
  input  logic       cc_io_ctrl,
  output logic       cc_lock,
  output logic [1:0] cc_orient,
  output logic       orient_flip,
  output logic       lock_lost,
  input  logic       phy_in_cc1,
  input  logic       phy_in_cc2,
  output logic       phy_out_en,
  output logic       phy_out_cc1,
  output logic       phy_out_cc2,
  output logic       phy_debug_cc1,
  output logic       phy_debug_cc2
);

  localparam int unsigned DEB_CYC = cc_cycles(SYSTEM_KHZ, DEBOUNCE_US, 1000);
  localparam int unsigned TO_CYC  = cc_cycles(SYSTEM_KHZ, SAMPLE_TO_US, 1000);
  localparam int unsigned RCK_CYC = cc_cycles(SYSTEM_KHZ, RECHECK_MS, 1);
  localparam int unsigned TW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam int unsigned RW = (RCK_CYC > 0) ? $clog2(RCK_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
  localparam logic [RW-1:0] RCK_LAST = RW'((RCK_CYC > 0) ? RCK_CYC - 1 : 0);
  localparam bit            RCK_EN   = (RCK_CYC != 0);

  logic sc1, sc2, stable;

  cc_sync_deb #(.DEB_CYC(DEB_CYC)) u_sync_deb (
    .clock      (clock),
    .nrst       (nrst),
    .phy_in_cc1 (phy_in_cc1),
    .phy_in_cc2 (phy_in_cc2),
    .sc1        (sc1),
    .sc2        (sc2),
    .stable     (stable)
  );

  cc_state_e     state_q, state_d;
  logic          lock_q, lock_d;
  logic [1:0]    orient_q, orient_d;
  logic          pend_q, pend_d;
  logic          flip_q, flip_d;
  logic          lost_q, lost_d;
  logic [TW-1:0] to_q, to_d;
  logic [RW-1:0] rck_q, rck_d;
  logic          rck_run, rck_exp;
  logic [1:0]    r;
  cc_state_e     home;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      orient_q <= 2'b00;
      pend_q   <= 1'b0;
      flip_q   <= 1'b0;
      lost_q   <= 1'b0;
      to_q     <= '0;
      rck_q    <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      orient_q <= orient_d;
      pend_q   <= pend_d;
      flip_q   <= flip_d;
      lost_q   <= lost_d;
      to_q     <= to_d;
      rck_q    <= rck_d;
    end
  end

  // lock_q only changes on evaluation, so it also records the state SAMPLE returns to.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    orient_d = orient_q;
    pend_d   = pend_q;
    flip_d   = 1'b0;
    lost_d   = 1'b0;
    to_d     = '0;
    rck_d    = rck_q;
    r        = {sc2, sc1} & {2{sc2 ^ sc1}};
    home     = lock_q ? LOCKED : IDLE;
    rck_run  = !cc_io_ctrl && (state_q != SAMPLE);
    rck_exp  = RCK_EN && rck_run && (rck_q == RCK_LAST);
    if (rck_run) begin
      rck_d = rck_exp ? '0 : rck_q + 1'b1;
    end
    case (state_q)
      IDLE, LOCKED: begin
        pend_d = pend_q | cc_check | rck_exp;
        if (pend_q && !cc_io_ctrl) begin
          state_d = SAMPLE;
          pend_d  = 1'b0;
        end
      end
      SAMPLE: begin
        rck_d  = '0;
        pend_d = 1'b0;
        to_d   = to_q + 1'b1;
        if (cc_io_ctrl) begin
          state_d = home;
          pend_d  = 1'b1;
        end else if (stable) begin
          state_d  = (r != 2'b00) ? LOCKED : IDLE;
          lock_d   = (r != 2'b00);
          orient_d = r;
          flip_d   = lock_q && (r != 2'b00) && (r != orient_q);
          lost_d   = lock_q && (r == 2'b00);
        end else if (to_q == TO_LAST) begin
          state_d = home;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cc_lock       = lock_q;
  assign cc_orient     = orient_q;
  assign orient_flip   = flip_q;
  assign lock_lost     = lost_q;
  assign phy_out_en    = !cc_io_ctrl;
  assign phy_out_cc1   = orient_q[0] & cc_dout & cc_io_ctrl;
  assign phy_out_cc2   = orient_q[1] & cc_dout & cc_io_ctrl;
  assign phy_debug_cc1 = sc1;
  assign phy_debug_cc2 = sc2;
  assign cc_din = cc_io_ctrl ? 1'b1
                : (RX_MASK && lock_q) ? |(orient_q & {sc2, sc1})
                : (sc1 | sc2);

endmodule

// File: tb/tb_cc_orient_ctrl.sv
// tb/tb_cc_orient_ctrl.sv - directed self-checking bench for cc_orient_ctrl
module tb_cc_orient_ctrl;

  logic       clock = 1'b0;
  logic       nrst = 1'b0;
  logic       cc_dout = 1'b0, cc_check = 1'b0, cc_io_ctrl = 1'b0;
  logic       phy_in_cc1 = 1'b0, phy_in_cc2 = 1'b0;
  logic       cc_din, cc_lock, orient_flip, lock_lost;
  logic [1:0] cc_orient;
  logic       phy_out_en, phy_out_cc1, phy_out_cc2, phy_debug_cc1, phy_debug_cc2;
  logic       u_din, u_lock, u_flip, u_lost, u_en, u_o1, u_o2, u_d1, u_d2;
  logic [1:0] u_orient;

  int errors = 0;
  int checks = 0;
  int flip_cnt = 0;
  int lost_cnt = 0;

  cc_orient_ctrl #(.SYSTEM_KHZ(1000), .DEBOUNCE_US(10), .SAMPLE_TO_US(100),
                   .RECHECK_MS(1), .RX_MASK(1'b1)) dut (
    .clock(clock), .nrst(nrst), .cc_din(cc_din), .cc_dout(cc_dout),
    .cc_check(cc_check), .cc_io_ctrl(cc_io_ctrl), .cc_lock(cc_lock),
    .cc_orient(cc_orient), .orient_flip(orient_flip), .lock_lost(lock_lost),
    .phy_in_cc1(phy_in_cc1), .phy_in_cc2(phy_in_cc2), .phy_out_en(phy_out_en),
    .phy_out_cc1(phy_out_cc1), .phy_out_cc2(phy_out_cc2),
    .phy_debug_cc1(phy_debug_cc1), .phy_debug_cc2(phy_debug_cc2));

  cc_orient_ctrl #(.SYSTEM_KHZ(1000), .DEBOUNCE_US(10), .SAMPLE_TO_US(100),
                   .RECHECK_MS(1), .RX_MASK(1'b0)) dut_nomask (
    .clock(clock), .nrst(nrst), .cc_din(u_din), .cc_dout(cc_dout),
    .cc_check(cc_check), .cc_io_ctrl(cc_io_ctrl), .cc_lock(u_lock),
    .cc_orient(u_orient), .orient_flip(u_flip), .lock_lost(u_lost),
    .phy_in_cc1(phy_in_cc1), .phy_in_cc2(phy_in_cc2), .phy_out_en(u_en),
    .phy_out_cc1(u_o1), .phy_out_cc2(u_o2),
    .phy_debug_cc1(u_d1), .phy_debug_cc2(u_d2));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (orient_flip === 1'b1) flip_cnt <= flip_cnt + 1;
    if (lock_lost === 1'b1) lost_cnt <= lost_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_check;
    cc_check = 1'b1;
    step(1);
    cc_check = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0; cc_io_ctrl = 1'b0; cc_dout = 1'b1;
    step(3);
    checks++; if (cc_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", cc_lock); end
    checks++; if (cc_orient !== 2'b00) begin errors++; $display("FAIL reset_orient: got %b want 00", cc_orient); end
    checks++; if (cc_din !== 1'b0) begin errors++; $display("FAIL reset_din_rx: got %b want 0", cc_din); end
    checks++; if (phy_out_en !== 1'b1) begin errors++; $display("FAIL reset_en_rx: got %b want 1", phy_out_en); end
    checks++; if ({orient_flip, lock_lost, phy_debug_cc2, phy_debug_cc1} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses_dbg: got %b want 0000", {orient_flip, lock_lost, phy_debug_cc2, phy_debug_cc1}); end
    cc_io_ctrl = 1'b1; #1;
    checks++; if (cc_din !== 1'b1) begin errors++; $display("FAIL reset_din_tx: got %b want 1", cc_din); end
    checks++; if ({phy_out_en, phy_out_cc2, phy_out_cc1} !== 3'b000) begin
      errors++; $display("FAIL reset_phy_tx: got %b want 000", {phy_out_en, phy_out_cc2, phy_out_cc1}); end
    cc_io_ctrl = 1'b0; cc_dout = 1'b0;
    step(1);
    nrst = 1'b1;
    step(2);
  endtask

  task automatic test_lock;
    phy_in_cc1 = 1'b1; phy_in_cc2 = 1'b0;
    pulse_check;
    step(1);
    checks++; if (cc_lock !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", cc_lock); end
    step(12);
    checks++; if (cc_lock !== 1'b1) begin errors++; $display("FAIL lock_14cyc: got %b want 1", cc_lock); end
    checks++; if (cc_orient !== 2'b01) begin errors++; $display("FAIL lock_orient: got %b want 01", cc_orient); end
    checks++; if ({u_lock, u_orient} !== 3'b101) begin errors++; $display("FAIL lock_nomask: got %b want 101", {u_lock, u_orient}); end
    cc_io_ctrl = 1'b1; cc_dout = 1'b1; #1;
    checks++; if ({phy_out_en, phy_out_cc2, phy_out_cc1, cc_din} !== 4'b0011) begin
      errors++; $display("FAIL lock_tx_path: got %b want 0011", {phy_out_en, phy_out_cc2, phy_out_cc1, cc_din}); end
    checks++; if (flip_cnt + lost_cnt !== 0) begin errors++; $display("FAIL lock_no_pulse: got %0d want 0", flip_cnt + lost_cnt); end
  endtask

  task automatic test_flip;
    int n; int f0; int l0; bit dropped;
    f0 = flip_cnt; l0 = lost_cnt; dropped = 1'b0;
    cc_io_ctrl = 1'b0; cc_dout = 1'b0;
    phy_in_cc1 = 1'b0; phy_in_cc2 = 1'b1;
    step(3);
    checks++; if (cc_din !== 1'b0) begin errors++; $display("FAIL rxmask_din: got %b want 0", cc_din); end
    checks++; if (u_din !== 1'b1) begin errors++; $display("FAIL nomask_din: got %b want 1", u_din); end
    n = 3;
    while (n < 1100 && cc_orient !== 2'b10) begin
      step(1); n++;
      if (cc_lock !== 1'b1) dropped = 1'b1;
    end
    step(2);
    checks++; if (cc_orient !== 2'b10) begin errors++; $display("FAIL flip_orient: got %b want 10", cc_orient); end
    checks++; if (n > 1014) begin errors++; $display("FAIL flip_latency: got %0d cycles want <= 1014", n); end
    checks++; if (dropped || cc_lock !== 1'b1) begin errors++; $display("FAIL flip_lock_held: got dropped=%b lock=%b want 0/1", dropped, cc_lock); end
    checks++; if (flip_cnt - f0 !== 1) begin errors++; $display("FAIL flip_pulse: got %0d want 1", flip_cnt - f0); end
    checks++; if (lost_cnt - l0 !== 0) begin errors++; $display("FAIL flip_no_lost: got %0d want 0", lost_cnt - l0); end
  endtask

  task automatic test_lost;
    int n; int f0; int l0;
    f0 = flip_cnt; l0 = lost_cnt;
    phy_in_cc1 = 1'b0; phy_in_cc2 = 1'b0;
    n = 0;
    while (n < 1100 && cc_lock !== 1'b0) begin step(1); n++; end
    step(2);
    checks++; if ({cc_lock, cc_orient} !== 3'b000) begin errors++; $display("FAIL lost_state: got %b want 000", {cc_lock, cc_orient}); end
    checks++; if (lost_cnt - l0 !== 1) begin errors++; $display("FAIL lost_pulse: got %0d want 1", lost_cnt - l0); end
    checks++; if (flip_cnt - f0 !== 0) begin errors++; $display("FAIL lost_no_flip: got %0d want 0", flip_cnt - f0); end
    cc_io_ctrl = 1'b1; cc_dout = 1'b1; #1;
    checks++; if ({phy_out_cc2, phy_out_cc1} !== 2'b00) begin errors++; $display("FAIL lost_phy_out: got %b want 00", {phy_out_cc2, phy_out_cc1}); end
    cc_io_ctrl = 1'b0; cc_dout = 1'b0;
    step(1);
  endtask

  task automatic test_no_stable;
    int f0; int l0; bit bad;
    phy_in_cc1 = 1'b1; phy_in_cc2 = 1'b0;
    pulse_check;
    step(20);
    checks++; if ({cc_lock, cc_orient} !== 3'b101) begin errors++; $display("FAIL relock: got %b want 101", {cc_lock, cc_orient}); end
    f0 = flip_cnt; l0 = lost_cnt; bad = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i == 0) cc_check = 1'b1;
      phy_in_cc1 = ~phy_in_cc1;
      step(1);
      cc_check = 1'b0;
      step(3);
      if ({cc_lock, cc_orient} !== 3'b101) bad = 1'b1;
    end
    phy_in_cc1 = 1'b0; phy_in_cc2 = 1'b1;
    step(30);
    checks++; if (bad || {cc_lock, cc_orient} !== 3'b101) begin errors++; $display("FAIL timeout_keeps: got bad=%b %b want 0/101", bad, {cc_lock, cc_orient}); end
    checks++; if (flip_cnt - f0 + lost_cnt - l0 !== 0) begin errors++; $display("FAIL timeout_no_pulse: got %0d want 0", flip_cnt - f0 + lost_cnt - l0); end
    phy_in_cc1 = 1'b1; phy_in_cc2 = 1'b0;
    step(20);
  endtask

  task automatic test_tx_freeze;
    int n; int f0;
    pulse_check;
    step(20);
    f0 = flip_cnt;
    step(480);
    cc_io_ctrl = 1'b1; phy_in_cc1 = 1'b0; phy_in_cc2 = 1'b1;
    step(1500);
    checks++; if (cc_orient !== 2'b01) begin errors++; $display("FAIL tx_no_sample: got %b want 01", cc_orient); end
    cc_io_ctrl = 1'b0;
    step(30);
    checks++; if (cc_orient !== 2'b01) begin errors++; $display("FAIL rck_frozen: got %b want 01", cc_orient); end
    n = 0;
    while (n < 600 && cc_orient !== 2'b10) begin step(1); n++; end
    step(2);
    checks++; if (cc_orient !== 2'b10 || flip_cnt - f0 !== 1) begin
      errors++; $display("FAIL rck_resumes: got %b flips=%0d want 10 flips=1", cc_orient, flip_cnt - f0); end
  endtask

  task automatic test_tx_check;
    cc_io_ctrl = 1'b1; phy_in_cc1 = 1'b1; phy_in_cc2 = 1'b0;
    pulse_check;
    step(50);
    checks++; if (cc_orient !== 2'b10) begin errors++; $display("FAIL check_in_tx: got %b want 10", cc_orient); end
    cc_io_ctrl = 1'b0;
    step(1);
    checks++; if (cc_orient !== 2'b10) begin errors++; $display("FAIL check_after_tx_early: got %b want 10", cc_orient); end
    step(1);
    checks++; if (cc_orient !== 2'b01) begin errors++; $display("FAIL check_after_tx: got %b want 01", cc_orient); end
  endtask

  task automatic test_abort;
    int f0;
    step(5);
    f0 = flip_cnt;
    phy_in_cc1 = 1'b0; phy_in_cc2 = 1'b1;
    pulse_check;
    step(3);
    cc_io_ctrl = 1'b1;
    step(30);
    checks++; if ({cc_lock, cc_orient} !== 3'b101) begin errors++; $display("FAIL abort_keeps: got %b want 101", {cc_lock, cc_orient}); end
    cc_io_ctrl = 1'b0;
    step(2);
    checks++; if (cc_orient !== 2'b10) begin errors++; $display("FAIL abort_resample: got %b want 10", cc_orient); end
    step(2);
    checks++; if (flip_cnt - f0 !== 1) begin errors++; $display("FAIL abort_flip: got %0d want 1", flip_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    phy_in_cc1 = 1'b1; phy_in_cc2 = 1'b0;
    pulse_check;
    step(4);
    checks++; if (cc_lock !== 1'b1) begin errors++; $display("FAIL mid_pre_lock: got %b want 1", cc_lock); end
    nrst = 1'b0; #1;
    checks++; if ({cc_lock, cc_orient, cc_din} !== 4'b0000) begin errors++; $display("FAIL mid_reset: got %b want 0000", {cc_lock, cc_orient, cc_din}); end
    checks++; if ({u_lock, u_orient} !== 3'b000) begin errors++; $display("FAIL mid_reset_nomask: got %b want 000", {u_lock, u_orient}); end
    cc_io_ctrl = 1'b1; #1;
    checks++; if (cc_din !== 1'b1) begin errors++; $display("FAIL mid_reset_din_tx: got %b want 1", cc_din); end
    step(2);
    nrst = 1'b1; cc_io_ctrl = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset;
    test_lock;
    test_flip;
    test_lost;
    test_no_stable;
    test_tx_freeze;
    test_tx_check;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
